// File: rtl/l15_store_splitter.sv
// Store-issue stage in front of the L1.5 request port. It takes one 64-bit
// store at a time. Byte-enable patterns that are not a naturally aligned byte,
// hword, word or dword are broken into single-byte packets, lowest byte first.
// The block also counts store packets that have not yet been acked, and it
// raises empty_o when nothing is held or pending, for fences.
module l15_store_splitter #(
  parameter int PADDR_WIDTH     = 40,
  parameter int TID_WIDTH       = 3,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   st_valid_i,
  output logic                   st_ready_o,
  input  logic [PADDR_WIDTH-1:0] st_paddr_i,
  input  logic [63:0]            st_data_i,
  input  logic [7:0]             st_be_i,
  input  logic                   st_nc_i,
  output logic                   l15_val_o,
  output logic [4:0]             l15_rqtype_o,
  output logic [2:0]             l15_size_o,
  output logic [PADDR_WIDTH-1:0] l15_address_o,
  output logic [63:0]            l15_data_o,
  output logic [7:0]             l15_be_o,
  output logic                   l15_nc_o,
  output logic [TID_WIDTH-1:0]   l15_threadid_o,
  input  logic                   l15_ack_i,
  input  logic                   l15_rtrn_val_i,
  input  logic [3:0]             l15_rtrn_type_i,
  output logic                   empty_o
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);
  localparam logic [3:0] RTRN_ST_ACK = 4'b0100;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PADDR_WIDTH-4:0] paddr_hi_q, paddr_hi_d;
  logic [63:0]            data_q, data_d;
  logic                   nc_q, nc_d;
  logic [7:0]             rem_be_q, rem_be_d;
  logic [OUT_W-1:0]       outstanding_q, outstanding_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;

  logic [2:0]  pkt_size_s;
  logic [2:0]  pkt_off_s;
  logic [7:0]  pkt_be_s;
  logic [63:0] pkt_data_s;
  logic        val_s;
  logic        issue_fire_s;
  logic        st_ack_s;
  logic        dec_s;
  logic        unused_paddr_lo_s;

  // Index of the lowest set bit of a byte enable (0 when none is set).
  function automatic logic [2:0] lowest_set(input logic [7:0] be);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (be[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // The dword address alone selects the line; the low address bits are not used.
  assign unused_paddr_lo_s = ^st_paddr_i[2:0];

  // Decode the current packet (size, offset, byte enable) from the bytes left to send.
  always_comb begin
    pkt_size_s = 3'b000;
    pkt_off_s  = lowest_set(rem_be_q);
    pkt_be_s   = rem_be_q & (8'h01 << pkt_off_s);
    case (rem_be_q)
      8'hFF: begin pkt_size_s = 3'b011; pkt_off_s = 3'd0; pkt_be_s = rem_be_q; end
      8'h0F: begin pkt_size_s = 3'b010; pkt_off_s = 3'd0; pkt_be_s = rem_be_q; end
      8'hF0: begin pkt_size_s = 3'b010; pkt_off_s = 3'd4; pkt_be_s = rem_be_q; end
      8'h03: begin pkt_size_s = 3'b001; pkt_off_s = 3'd0; pkt_be_s = rem_be_q; end
      8'h0C: begin pkt_size_s = 3'b001; pkt_off_s = 3'd2; pkt_be_s = rem_be_q; end
      8'h30: begin pkt_size_s = 3'b001; pkt_off_s = 3'd4; pkt_be_s = rem_be_q; end
      8'hC0: begin pkt_size_s = 3'b001; pkt_off_s = 3'd6; pkt_be_s = rem_be_q; end
      default: begin
        pkt_size_s = 3'b000;
        pkt_off_s  = lowest_set(rem_be_q);
        pkt_be_s   = rem_be_q & (8'h01 << pkt_off_s);
      end
    endcase
  end

  // Replicate the selected byte(s) across the whole 64-bit bus.
  always_comb begin
    pkt_data_s = 64'd0;
    case (pkt_size_s)
      3'b000:  pkt_data_s = {8{data_q[{pkt_off_s, 3'b000} +: 8]}};
      3'b001:  pkt_data_s = {4{data_q[{pkt_off_s, 3'b000} +: 16]}};
      3'b010:  pkt_data_s = {2{data_q[{pkt_off_s, 3'b000} +: 32]}};
      3'b011:  pkt_data_s = data_q;
      default: pkt_data_s = 64'd0;
    endcase
  end

  assign val_s        = (state_q == ISSUE) && (outstanding_q < MAX_OUT);
  assign issue_fire_s = val_s && l15_ack_i;
  assign st_ack_s     = l15_rtrn_val_i && (l15_rtrn_type_i == RTRN_ST_ACK);
  assign dec_s        = st_ack_s && (outstanding_q != {OUT_W{1'b0}});

  assign st_ready_o     = (state_q == IDLE);
  assign l15_val_o      = val_s;
  assign l15_rqtype_o   = 5'b00001;
  assign l15_size_o     = pkt_size_s;
  assign l15_address_o  = {paddr_hi_q, pkt_off_s};
  assign l15_data_o     = pkt_data_s;
  assign l15_be_o       = pkt_be_s;
  assign l15_nc_o       = nc_q;
  assign l15_threadid_o = tid_q;
  assign empty_o        = (state_q == IDLE) && (outstanding_q == {OUT_W{1'b0}});

  // Next-state logic: capture a store, retire sent bytes, and track acks and tids.
  always_comb begin
    state_d       = state_q;
    paddr_hi_d    = paddr_hi_q;
    data_d        = data_q;
    nc_d          = nc_q;
    rem_be_d      = rem_be_q;
    outstanding_d = outstanding_q;
    tid_d         = tid_q;

    case (state_q)
      IDLE: begin
        if (st_valid_i) begin
          paddr_hi_d = st_paddr_i[PADDR_WIDTH-1:3];
          data_d     = st_data_i;
          nc_d       = st_nc_i;
          rem_be_d   = st_be_i;
          if (st_be_i != 8'h00) begin
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (issue_fire_s) begin
          rem_be_d = rem_be_q & ~pkt_be_s;
          if ((rem_be_q & ~pkt_be_s) == 8'h00) begin
            state_d = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue_fire_s && !dec_s) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!issue_fire_s && dec_s) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end else begin
      outstanding_d = outstanding_q;
    end

    if (issue_fire_s) begin
      tid_d = tid_q + TID_WIDTH'(1);
    end else begin
      tid_d = tid_q;
    end
  end

  // State registers with synchronous reset; reset abandons any split and pending acks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      paddr_hi_q    <= '0;
      data_q        <= 64'd0;
      nc_q          <= 1'b0;
      rem_be_q      <= 8'h00;
      outstanding_q <= '0;
      tid_q         <= '0;
    end else begin
      state_q       <= state_d;
      paddr_hi_q    <= paddr_hi_d;
      data_q        <= data_d;
      nc_q          <= nc_d;
      rem_be_q      <= rem_be_d;
      outstanding_q <= outstanding_d;
      tid_q         <= tid_d;
    end
  end

endmodule

// File: tb/tb_l15_store_splitter.sv
// Directed bench for l15_store_splitter: hand-computed packets per scenario.
module tb_l15_store_splitter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [39:0] st_paddr_i;
  logic [63:0] st_data_i;
  logic [7:0]  st_be_i;
  logic        st_nc_i;
  logic        l15_val_o;
  logic [4:0]  l15_rqtype_o;
  logic [2:0]  l15_size_o;
  logic [39:0] l15_address_o;
  logic [63:0] l15_data_o;
  logic [7:0]  l15_be_o;
  logic        l15_nc_o;
  logic [2:0]  l15_threadid_o;
  logic        l15_ack_i;
  logic        l15_rtrn_val_i;
  logic [3:0]  l15_rtrn_type_i;
  logic        empty_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // {val, size, be, address, data}
  logic [115:0] pkt;
  assign pkt = {l15_val_o, l15_size_o, l15_be_o, l15_address_o, l15_data_o};

  l15_store_splitter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .st_paddr_i(st_paddr_i), .st_data_i(st_data_i), .st_be_i(st_be_i), .st_nc_i(st_nc_i),
    .l15_val_o(l15_val_o), .l15_rqtype_o(l15_rqtype_o), .l15_size_o(l15_size_o),
    .l15_address_o(l15_address_o), .l15_data_o(l15_data_o), .l15_be_o(l15_be_o),
    .l15_nc_o(l15_nc_o), .l15_threadid_o(l15_threadid_o), .l15_ack_i(l15_ack_i),
    .l15_rtrn_val_i(l15_rtrn_val_i), .l15_rtrn_type_i(l15_rtrn_type_i), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic start_store(input logic [39:0] a, input logic [63:0] d, input logic [7:0] be, input logic nc);
    st_valid_i = 1'b1; st_paddr_i = a; st_data_i = d; st_be_i = be; st_nc_i = nc;
    tick();
    st_valid_i = 1'b0;
  endtask

  task automatic return_acks(input int n);
    l15_rtrn_val_i = 1'b1; l15_rtrn_type_i = 4'b0100;
    for (int i = 0; i < n; i++) tick();
    l15_rtrn_val_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({st_ready_o, l15_val_o, empty_o, l15_nc_o} !== 4'b1010) begin
      n_fail++; $display("FAIL reset_flags: actual %b required 1010", {st_ready_o, l15_val_o, empty_o, l15_nc_o});
    end
    n_cmp++;
    if (pkt !== 116'd0) begin
      n_fail++; $display("FAIL reset_pkt: actual %h required 0", pkt);
    end
    n_cmp++;
    if ({l15_threadid_o, l15_rqtype_o} !== {3'd0, 5'b00001}) begin
      n_fail++; $display("FAIL reset_tid_rqtype: actual %h required 01", {l15_threadid_o, l15_rqtype_o});
    end
    rst_i = 1'b0;
  endtask

  task automatic test_dword();
    l15_ack_i = 1'b1;
    start_store(40'h80001008, 64'h1122334455667788, 8'hFF, 1'b1);
    n_cmp++;
    if (pkt !== {1'b1, 3'b011, 8'hFF, 40'h80001008, 64'h1122334455667788}) begin
      n_fail++; $display("FAIL dword_pkt: actual %h", pkt);
    end
    n_cmp++;
    if ({st_ready_o, l15_nc_o, l15_threadid_o} !== {1'b0, 1'b1, 3'd0}) begin
      n_fail++; $display("FAIL dword_ready_nc_tid: actual %b required 01000", {st_ready_o, l15_nc_o, l15_threadid_o});
    end
    tick();
    l15_ack_i = 1'b0;
    n_cmp++;
    if ({st_ready_o, l15_val_o, empty_o} !== 3'b100) begin
      n_fail++; $display("FAIL dword_done: actual %b required 100", {st_ready_o, l15_val_o, empty_o});
    end
    return_acks(1);
    n_cmp++;
    if (empty_o !== 1'b1) begin
      n_fail++; $display("FAIL dword_empty: actual %b required 1", empty_o);
    end
  endtask

  task automatic test_upper_word();
    l15_ack_i = 1'b1;
    start_store(40'h1000, 64'hAABBCCDD_00000000, 8'hF0, 1'b0);
    n_cmp++;
    if (pkt !== {1'b1, 3'b010, 8'hF0, 40'h1004, 64'hAABBCCDD_AABBCCDD}) begin
      n_fail++; $display("FAIL word_pkt: actual %h", pkt);
    end
    n_cmp++;
    if ({l15_threadid_o, l15_nc_o} !== {3'd1, 1'b0}) begin
      n_fail++; $display("FAIL word_tid_nc: actual %b required 0010", {l15_threadid_o, l15_nc_o});
    end
    tick();
    l15_ack_i = 1'b0;
    return_acks(1);
  endtask

  task automatic test_split();
    do_reset();
    l15_ack_i = 1'b1;
    start_store(40'h2000, 64'h0000_0000_00CC_BB00, 8'h16, 1'b0);
    n_cmp++;
    if ({pkt, l15_threadid_o} !== {1'b1, 3'b000, 8'h02, 40'h2001, 64'hBBBB_BBBB_BBBB_BBBB, 3'd0}) begin
      n_fail++; $display("FAIL split_pkt0: actual %h tid %0d", pkt, l15_threadid_o);
    end
    tick();
    n_cmp++;
    if ({pkt, l15_threadid_o} !== {1'b1, 3'b000, 8'h04, 40'h2002, 64'hCCCC_CCCC_CCCC_CCCC, 3'd1}) begin
      n_fail++; $display("FAIL split_pkt1: actual %h tid %0d", pkt, l15_threadid_o);
    end
    tick();
    n_cmp++;
    if ({pkt, l15_threadid_o} !== {1'b1, 3'b000, 8'h10, 40'h2004, 64'h0, 3'd2}) begin
      n_fail++; $display("FAIL split_pkt2: actual %h tid %0d", pkt, l15_threadid_o);
    end
    tick();
    l15_ack_i = 1'b0;
    n_cmp++;
    if ({st_ready_o, l15_val_o, empty_o} !== 3'b100) begin
      n_fail++; $display("FAIL split_done: actual %b required 100", {st_ready_o, l15_val_o, empty_o});
    end
    return_acks(3);
    n_cmp++;
    if (empty_o !== 1'b1) begin
      n_fail++; $display("FAIL split_empty: actual %b required 1", empty_o);
    end
  endtask

  task automatic test_ack_stall();
    l15_ack_i = 1'b0;
    start_store(40'h3000, 64'h0000_0000_00CC_BB00, 8'h16, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (pkt !== {1'b1, 3'b000, 8'h02, 40'h3001, 64'hBBBB_BBBB_BBBB_BBBB}) begin
        n_fail++; $display("FAIL stall_hold%0d: actual %h", i, pkt);
      end
      tick();
    end
    l15_ack_i = 1'b1;
    tick();
    n_cmp++;
    if (pkt !== {1'b1, 3'b000, 8'h04, 40'h3002, 64'hCCCC_CCCC_CCCC_CCCC}) begin
      n_fail++; $display("FAIL stall_next: actual %h", pkt);
    end
    tick();
    tick();
    l15_ack_i = 1'b0;
    n_cmp++;
    if (st_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL stall_ready: actual %b required 1", st_ready_o);
    end
    return_acks(3);
  endtask

  task automatic test_outstanding();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      l15_ack_i = 1'b0;
      start_store(40'h4000 + 40'(i * 8), 64'(i), 8'hFF, 1'b0);
      n_cmp++;
      if (l15_val_o !== 1'b1) begin
        n_fail++; $display("FAIL limit_fill%0d: actual val %b required 1", i, l15_val_o);
      end
      l15_ack_i = 1'b1;
      tick();
    end
    l15_ack_i = 1'b0;
    start_store(40'h5000, 64'h7700_0000_0000_2211, 8'h83, 1'b0);
    n_cmp++;
    if ({st_ready_o, l15_val_o, empty_o} !== 3'b000) begin
      n_fail++; $display("FAIL limit_gate: actual %b required 000", {st_ready_o, l15_val_o, empty_o});
    end
    tick();
    n_cmp++;
    if (l15_val_o !== 1'b0) begin
      n_fail++; $display("FAIL limit_gate_hold: actual %b required 0", l15_val_o);
    end
    return_acks(1);
    n_cmp++;
    if (pkt !== {1'b1, 3'b000, 8'h01, 40'h5000, 64'h1111_1111_1111_1111}) begin
      n_fail++; $display("FAIL limit_reopen: actual %h", pkt);
    end
    l15_ack_i = 1'b1; l15_rtrn_val_i = 1'b1; l15_rtrn_type_i = 4'b0100;
    tick();
    l15_ack_i = 1'b0; l15_rtrn_val_i = 1'b0;
    n_cmp++;
    if (pkt !== {1'b1, 3'b000, 8'h02, 40'h5001, 64'h2222_2222_2222_2222}) begin
      n_fail++; $display("FAIL limit_simul: actual %h", pkt);
    end
    l15_ack_i = 1'b1;
    tick();
    l15_ack_i = 1'b0;
    n_cmp++;
    if ({st_ready_o, l15_val_o} !== 2'b00) begin
      n_fail++; $display("FAIL limit_refull: actual %b required 00", {st_ready_o, l15_val_o});
    end
    return_acks(1);
    n_cmp++;
    if (pkt !== {1'b1, 3'b000, 8'h80, 40'h5007, 64'h7777_7777_7777_7777}) begin
      n_fail++; $display("FAIL limit_last: actual %h", pkt);
    end
    l15_ack_i = 1'b1;
    tick();
    l15_ack_i = 1'b0;
    n_cmp++;
    if ({st_ready_o, l15_val_o, empty_o} !== 3'b100) begin
      n_fail++; $display("FAIL limit_idle: actual %b required 100", {st_ready_o, l15_val_o, empty_o});
    end
    l15_rtrn_val_i = 1'b1; l15_rtrn_type_i = 4'b0001;
    tick();
    l15_rtrn_val_i = 1'b0;
    return_acks(7);
    n_cmp++;
    if (empty_o !== 1'b0) begin
      n_fail++; $display("FAIL limit_not_empty: actual %b required 0", empty_o);
    end
    return_acks(1);
    n_cmp++;
    if (empty_o !== 1'b1) begin
      n_fail++; $display("FAIL limit_empty: actual %b required 1", empty_o);
    end
  endtask

  task automatic test_edges();
    l15_ack_i = 1'b0;
    start_store(40'h6000, 64'hDEAD_BEEF_0000_0000, 8'h00, 1'b0);
    n_cmp++;
    if ({st_ready_o, l15_val_o, empty_o} !== 3'b101) begin
      n_fail++; $display("FAIL be_zero: actual %b required 101", {st_ready_o, l15_val_o, empty_o});
    end
    return_acks(1);
    l15_ack_i = 1'b1;
    start_store(40'h6008, 64'h0102030405060708, 8'hFF, 1'b0);
    tick();
    l15_ack_i = 1'b0;
    n_cmp++;
    if ({st_ready_o, empty_o} !== 2'b10) begin
      n_fail++; $display("FAIL sat_pending: actual %b required 10", {st_ready_o, empty_o});
    end
    return_acks(1);
    n_cmp++;
    if (empty_o !== 1'b1) begin
      n_fail++; $display("FAIL sat_empty: actual %b required 1", empty_o);
    end
    l15_ack_i = 1'b1;
    start_store(40'h2000, 64'h0000_0000_00CC_BB00, 8'h16, 1'b1);
    tick();
    rst_i = 1'b1;
    l15_ack_i = 1'b0;
    tick();
    rst_i = 1'b0;
    n_cmp++;
    if ({st_ready_o, l15_val_o, empty_o, l15_nc_o, l15_threadid_o} !== {4'b1010, 3'd0}) begin
      n_fail++; $display("FAIL mid_reset: actual %b required 1010000", {st_ready_o, l15_val_o, empty_o, l15_nc_o, l15_threadid_o});
    end
    n_cmp++;
    if (pkt !== 116'd0) begin
      n_fail++; $display("FAIL mid_reset_pkt: actual %h required 0", pkt);
    end
  endtask

  initial begin
    rst_i = 1'b1; st_valid_i = 1'b0; st_paddr_i = 40'd0; st_data_i = 64'd0;
    st_be_i = 8'h00; st_nc_i = 1'b0; l15_ack_i = 1'b0;
    l15_rtrn_val_i = 1'b0; l15_rtrn_type_i = 4'b0000;
    test_reset();
    test_dword();
    test_upper_word();
    test_split();
    test_ack_stall();
    test_outstanding();
    test_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
